// File: rtl/gt_link_bringup_ctrl.sv
// Bring-up and supervision controller for an N-channel GT bridge quad: sequences GT reset,
// waits for PLL lock / reset-done / link, retries on timeout and re-trains after debounced link loss.
module gt_link_bringup_ctrl #(
    parameter int N_CH       = 4,
    parameter int RATE_W     = 4,
    parameter int RST_CYCLES = 64,
    parameter int TMO_W      = 16,
    parameter int DEBOUNCE   = 16,
    parameter int MAX_RETRY  = 7,
    localparam int RC_W      = $clog2(MAX_RETRY + 1)
) (
    input  logic              apb3clk,
    input  logic              gt_reset,
    input  logic              enable,
    input  logic              rate_req,
    input  logic [RATE_W-1:0] rate_req_val,
    input  logic              lcpll_lock,
    input  logic              rpll_lock,
    input  logic [N_CH-1:0]   tx_resetdone,
    input  logic [N_CH-1:0]   rx_resetdone,
    input  logic [N_CH-1:0]   link_status,
    output logic              gt_reset_out,
    output logic [RATE_W-1:0] rate_sel,
    output logic              rate_ack,
    output logic              link_up,
    output logic              fail,
    output logic [RC_W-1:0]   retry_cnt,
    output logic [2:0]        state_dbg
);

    localparam int SW     = 3 * N_CH + 2;
    localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int DB_W   = $clog2(DEBOUNCE + 1);

    localparam logic [RCNT_W-1:0] RST_LAST      = RCNT_W'(RST_CYCLES - 1);
    localparam logic [DB_W-1:0]   DEB_LAST      = DB_W'(DEBOUNCE - 1);
    localparam logic [RC_W-1:0]   RETRY_SAT     = RC_W'(MAX_RETRY);
    localparam logic [RC_W-1:0]   RETRY_FAIL_AT = RC_W'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RST       = 3'd1,
        S_WAIT_PLL  = 3'd2,
        S_WAIT_RD   = 3'd3,
        S_WAIT_LINK = 3'd4,
        S_LINK_UP   = 3'd5,
        S_FAIL      = 3'd6
    } state_t;

    function automatic logic [RC_W-1:0] retry_sat_inc(input logic [RC_W-1:0] v);
        return (v == RETRY_SAT) ? v : v + 1'b1;
    endfunction

    // Stage p0/p1: two-flop synchroniser for every asynchronous GT status input
    logic [SW-1:0] stat_raw;
    logic [SW-1:0] sync_p0_q;
    logic [SW-1:0] sync_p1_q;

    assign stat_raw = {link_status, rx_resetdone, tx_resetdone, rpll_lock, lcpll_lock};

    always_ff @(posedge apb3clk or posedge gt_reset) begin
        if (gt_reset) begin
            sync_p0_q <= '0;
            sync_p1_q <= '0;
        end else begin
            sync_p0_q <= stat_raw;
            sync_p1_q <= sync_p0_q;
        end
    end

    logic            lcpll_s;
    logic            rpll_s;
    logic [N_CH-1:0] tx_rd_s;
    logic [N_CH-1:0] rx_rd_s;
    logic [N_CH-1:0] link_s;
    logic            pll_ok;
    logic            rd_ok;
    logic            link_ok;
    logic            link_loss;

    assign lcpll_s   = sync_p1_q[0];
    assign rpll_s    = sync_p1_q[1];
    assign tx_rd_s   = sync_p1_q[2 +: N_CH];
    assign rx_rd_s   = sync_p1_q[2 + N_CH +: N_CH];
    assign link_s    = sync_p1_q[2 + 2 * N_CH +: N_CH];
    assign pll_ok    = lcpll_s & rpll_s;
    assign rd_ok     = (&tx_rd_s) & (&rx_rd_s);
    assign link_ok   = &link_s;
    // A PLL dropping lock while up is treated exactly like a lane losing link
    assign link_loss = !(link_ok && pll_ok);

    // Stage p2: sequencing FSM and its counters
    state_t              state_q, state_d;
    logic [RCNT_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [DB_W-1:0]     deb_q, deb_d;
    logic [RC_W-1:0]     retry_q, retry_d;
    logic [RATE_W-1:0]   rate_sel_q, rate_sel_d;
    logic                rate_ack_q, rate_ack_d;
    logic                rate_ok;
    logic                timed_out;

    assign rate_ok = rate_req && enable &&
                     (state_q inside {S_IDLE, S_LINK_UP, S_FAIL});

    always_ff @(posedge apb3clk or posedge gt_reset) begin
        if (gt_reset) begin
            state_q    <= S_IDLE;
            rst_cnt_q  <= '0;
            tmo_q      <= '0;
            deb_q      <= '0;
            retry_q    <= '0;
            rate_sel_q <= '0;
            rate_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            tmo_q      <= tmo_d;
            deb_q      <= deb_d;
            retry_q    <= retry_d;
            rate_sel_q <= rate_sel_d;
            rate_ack_q <= rate_ack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        tmo_d      = tmo_q;
        deb_d      = deb_q;
        retry_d    = retry_q;
        rate_sel_d = rate_sel_q;
        rate_ack_d = 1'b0;
        timed_out  = 1'b0;

        case (state_q)
            S_IDLE: begin
                retry_d = '0;
                if (enable) state_d = S_RST;
            end
            S_RST: begin
                if (rst_cnt_q == RST_LAST) state_d = S_WAIT_PLL;
                else                       rst_cnt_d = rst_cnt_q + 1'b1;
            end
            S_WAIT_PLL: begin
                tmo_d = tmo_q + 1'b1;
                if (pll_ok)       state_d = S_WAIT_RD;
                else if (&tmo_q)  timed_out = 1'b1;
            end
            S_WAIT_RD: begin
                tmo_d = tmo_q + 1'b1;
                if (rd_ok)        state_d = S_WAIT_LINK;
                else if (&tmo_q)  timed_out = 1'b1;
            end
            S_WAIT_LINK: begin
                tmo_d = tmo_q + 1'b1;
                if (link_ok) begin
                    state_d = S_LINK_UP;
                    retry_d = '0;
                end else if (&tmo_q) begin
                    timed_out = 1'b1;
                end
            end
            S_LINK_UP: begin
                if (!link_loss)              deb_d = '0;
                else if (deb_q == DEB_LAST)  state_d = S_RST;
                else                         deb_d = deb_q + 1'b1;
            end
            S_FAIL:  state_d = S_FAIL;
            default: state_d = S_IDLE;
        endcase

        if (timed_out) begin
            retry_d = retry_sat_inc(retry_q);
            state_d = (retry_d > RETRY_FAIL_AT) ? S_FAIL : S_RST;
        end

        // rate_sel changes while GT is still held in reset (IDLE/FAIL) or is about to be
        if (rate_ok) begin
            rate_sel_d = rate_req_val;
            rate_ack_d = 1'b1;
            if (state_q != S_IDLE) state_d = S_RST;
            if (state_q == S_FAIL) retry_d = '0;
        end

        if (!enable) begin
            state_d = S_IDLE;
            retry_d = '0;
        end

        if (state_d != state_q) begin
            rst_cnt_d = '0;
            tmo_d     = '0;
            deb_d     = '0;
        end
    end

    assign gt_reset_out = !(state_q inside {S_WAIT_PLL, S_WAIT_RD, S_WAIT_LINK, S_LINK_UP});
    assign link_up      = (state_q == S_LINK_UP);
    assign fail         = (state_q == S_FAIL);
    assign rate_sel     = rate_sel_q;
    assign rate_ack     = rate_ack_q;
    assign retry_cnt    = retry_q;
    assign state_dbg    = state_q;

endmodule
